// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift/rotate/arithmetic-shift/load/clear operations
// and a burst engine that runs N back-to-back shifts from a single start pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | honours select each cycle; a start request launches a burst
// ST_SHIFT | one shift per edge in burst_dir until remaining reaches zero
// ST_DONE  | done pulse cycle; out holds, then returns to ST_IDLE
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic [2:0]       select,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             burst_dir,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] count_c;

    // Requests longer than the register are clamped; extra shifts would only refill serial_in.
    assign count_c = (count > WIDTH_C) ? WIDTH_C : count;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count_c == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        rem_d   = count_c;
                        busy_d  = 1'b1;
                    end
                end else begin
                    case (select)
                        OP_HOLD: ;
                        OP_SHR: begin
                            out_d  = {serial_in, out_q[WIDTH-1:1]};
                            sout_d = out_q[0];
                        end
                        OP_SHL: begin
                            out_d  = {out_q[WIDTH-2:0], serial_in};
                            sout_d = out_q[WIDTH-1];
                        end
                        OP_LOAD: out_d = parallel_in;
                        OP_ROR: begin
                            out_d  = {out_q[0], out_q[WIDTH-1:1]};
                            sout_d = out_q[0];
                        end
                        OP_ROL: begin
                            out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                            sout_d = out_q[WIDTH-1];
                        end
                        OP_ASR: begin
                            out_d  = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                            sout_d = out_q[0];
                        end
                        OP_CLR: out_d = '0;
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (burst_dir) begin
                    out_d  = {out_q[WIDTH-2:0], serial_in};
                    sout_d = out_q[WIDTH-1];
                end else begin
                    out_d  = {serial_in, out_q[WIDTH-1:1]};
                    sout_d = out_q[0];
                end
                rem_d = rem_q - ONE_C;
                if (rem_q == ONE_C) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    assign out        = out_q;
    assign serial_out = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): a reference model pushes the expected state for every
// edge onto a scoreboard, popped and compared after the edge, plus directed checks.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_in;
    logic [W-1:0]  parallel_in;
    logic [2:0]    select;
    logic          start;
    logic [CW-1:0] count;
    logic          burst_dir;
    logic [W-1:0]  out;
    logic          serial_out;
    logic          busy;
    logic          done;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .parallel_in(parallel_in),
        .select(select), .start(start), .count(count), .burst_dir(burst_dir),
        .out(out), .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] o;
        logic         so;
        logic         b;
        logic         d;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    logic [W-1:0]  m_out = '0;
    logic          m_so = 1'b0, m_b = 1'b0, m_d = 1'b0;
    int            m_st = 0;
    int            m_rem = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge given the inputs currently driven.
    task automatic model_step();
        logic [W-1:0] o;
        int c;
        o = m_out;
        if (!reset) begin
            m_out = '0; m_so = 1'b0; m_b = 1'b0; m_d = 1'b0; m_st = 0; m_rem = 0;
        end else if (m_st == 0) begin
            m_d = 1'b0;
            if (start) begin
                c = (int'(count) > W) ? W : int'(count);
                if (c == 0) begin
                    m_st = 2; m_d = 1'b1;
                end else begin
                    m_st = 1; m_rem = c; m_b = 1'b1;
                end
            end else begin
                case (select)
                    3'b001: begin m_out = {serial_in, o[W-1:1]}; m_so = o[0]; end
                    3'b010: begin m_out = {o[W-2:0], serial_in}; m_so = o[W-1]; end
                    3'b011: m_out = parallel_in;
                    3'b100: begin m_out = {o[0], o[W-1:1]}; m_so = o[0]; end
                    3'b101: begin m_out = {o[W-2:0], o[W-1]}; m_so = o[W-1]; end
                    3'b110: begin m_out = {o[W-1], o[W-1:1]}; m_so = o[0]; end
                    3'b111: m_out = '0;
                    default: ;
                endcase
            end
        end else if (m_st == 1) begin
            if (burst_dir) begin m_out = {o[W-2:0], serial_in}; m_so = o[W-1]; end
            else begin m_out = {serial_in, o[W-1:1]}; m_so = o[0]; end
            m_rem--;
            if (m_rem == 0) begin m_st = 2; m_b = 1'b0; m_d = 1'b1; end
        end else begin
            m_d = 1'b0; m_st = 0;
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        sb_q.push_back('{o: m_out, so: m_so, b: m_b, d: m_d});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_out", 64'(out), 64'(e.o));
        check("sb_sout", 64'(serial_out), 64'(e.so));
        check("sb_busy", 64'(busy), 64'(e.b));
        check("sb_done", 64'(done), 64'(e.d));
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic op(input logic [2:0] s, input logic si, input logic [W-1:0] pin);
        select = s; serial_in = si; parallel_in = pin;
        cycle();
    endtask

    int lat;

    initial begin
        reset = 1'b0; serial_in = 1'b0; parallel_in = '0; select = 3'b000;
        start = 1'b0; count = '0; burst_dir = 1'b0;
        #2;
        run(2);
        check("rst_out", 64'(out), 64'h00);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);

        reset = 1'b1;
        op(3'b011, 1'b0, 8'hA5);
        check("load", 64'(out), 64'hA5);
        op(3'b001, 1'b1, 8'h00);
        check("shr", 64'(out), 64'hD2);
        check("shr_so", 64'(serial_out), 64'h1);
        op(3'b101, 1'b0, 8'h00);
        check("rol", 64'(out), 64'hA5);
        check("rol_so", 64'(serial_out), 64'h1);
        op(3'b011, 1'b0, 8'h80);
        op(3'b110, 1'b0, 8'h00);
        check("asr", 64'(out), 64'hC0);
        check("asr_so", 64'(serial_out), 64'h0);
        op(3'b010, 1'b1, 8'h00);
        op(3'b100, 1'b0, 8'h00);
        op(3'b000, 1'b0, 8'h00);
        op(3'b111, 1'b0, 8'h00);
        check("clr", 64'(out), 64'h00);

        // burst right by 3 with a clear request held during busy
        op(3'b011, 1'b0, 8'hA5);
        select = 3'b000;
        done_cnt = 0; busy_cnt = 0;
        start = 1'b1; count = 4'd3; burst_dir = 1'b0; serial_in = 1'b0;
        cycle();
        lat = 1;
        start = 1'b0; select = 3'b111;
        while (!done && lat < 20) begin cycle(); lat++; end
        check("b3_latency", 64'(lat), 64'd4);
        check("b3_busy_cycles", 64'(busy_cnt), 64'd3);
        check("b3_out", 64'(out), 64'h14);
        check("b3_so", 64'(serial_out), 64'h1);
        select = 3'b000;
        run(2);
        check("b3_done_pulses", 64'(done_cnt), 64'd1);

        // zero-length burst
        busy_cnt = 0;
        start = 1'b1; count = 4'd0;
        cycle();
        check("b0_done", 64'(done), 64'h1);
        check("b0_out", 64'(out), 64'h14);
        start = 1'b0;
        run(2);
        check("b0_busy", 64'(busy_cnt), 64'd0);

        // clamped burst left
        busy_cnt = 0;
        start = 1'b1; count = 4'd15; burst_dir = 1'b1; serial_in = 1'b1;
        cycle();
        start = 1'b0;
        run(10);
        check("b15_out", 64'(out), 64'hFF);
        check("b15_busy_cycles", 64'(busy_cnt), 64'd8);

        // reset mid-burst
        serial_in = 1'b0; burst_dir = 1'b0;
        op(3'b011, 1'b0, 8'h3C);
        select = 3'b000; done_cnt = 0;
        start = 1'b1; count = 4'd8;
        cycle();
        start = 1'b0;
        run(3);
        reset = 1'b0;
        cycle();
        check("mid_rst_out", 64'(out), 64'h00);
        check("mid_rst_busy", 64'(busy), 64'h0);
        reset = 1'b1;
        run(12);
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        op(3'b011, 1'b0, 8'h81);
        select = 3'b000;
        start = 1'b1; count = 4'd2; serial_in = 1'b1;
        cycle();
        check("post_rst_start", 64'(busy), 64'h1);
        start = 1'b0;
        run(4);
        check("post_rst_out", 64'(out), 64'hE0);
        check("post_rst_done", 64'(done_cnt), 64'd1);

        // start held through SHIFT and DONE: only one burst
        done_cnt = 0; serial_in = 1'b0; burst_dir = 1'b1;
        start = 1'b1; count = 4'd2;
        run(4);
        start = 1'b0;
        run(3);
        check("held_start_done", 64'(done_cnt), 64'd1);
        check("held_start_out", 64'(out), 64'h80);
        start = 1'b1; count = 4'd1;
        cycle();
        check("idle_start_busy", 64'(busy), 64'h1);
        start = 1'b0;
        run(3);
        check("idle_start_out", 64'(out), 64'h00);
        check("idle_start_done", 64'(done_cnt), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
